// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin write arbiter: N_REQ producers share one FIFO write port, bursts of up to MAX_BURST beats.
// Latency: one IDLE decision cycle before the first write of each grant; writes are combinational in BURST.
// Backpressure: fifo_full clears the granted req_ready and stalls the burst in place; it never ends a grant.
module fifo_wr_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int F_WIDTH   = 32,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*F_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [F_WIDTH-1:0]       fifo_wr_data,
  output logic                     grant_valid,
  output logic [ID_W-1:0]          grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_ptr_nxt;
  logic [ID_W-1:0]  grant_id_nxt;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_nxt;
  logic [ID_W-1:0]  pick_id;
  logic             pick_vld;
  logic [ID_W-1:0]  next_id;

  // Round-robin search: scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_id  = rr_ptr;
    pick_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        pick_id  = ID_W'((int'(rr_ptr) + k) % N_REQ);
        pick_vld = 1'b1;
      end
    end
  end

  // Write data follows grant_id in every state; it only matters while fifo_wr_en is high.
  always_comb begin
    fifo_wr_data = req_data[F_WIDTH-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        fifo_wr_data = req_data[i*F_WIDTH +: F_WIDTH];
      end
    end
  end

  // Pointer to the requester after the current grant, wrapping N_REQ-1 back to 0.
  always_comb begin
    next_id = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Next-state and handshake outputs; handshakes are held low while reset is asserted.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_id_nxt  = grant_id;
    burst_cnt_nxt = burst_cnt;
    req_ready     = '0;
    fifo_wr_en    = 1'b0;
    grant_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_id_nxt  = pick_id;
          burst_cnt_nxt = '0;
          state_nxt     = BURST;
        end
      end
      BURST: begin
        grant_valid         = 1'b1;
        req_ready[grant_id] = ~fifo_full;
        fifo_wr_en          = req_valid[grant_id] & ~fifo_full;
        if (!req_valid[grant_id]) begin
          // Producer went idle: release the grant without taking a beat.
          state_nxt  = IDLE;
          rr_ptr_nxt = next_id;
        end else if (fifo_wr_en) begin
          if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = next_id;
          end else begin
            burst_cnt_nxt = burst_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      req_ready   = '0;
      fifo_wr_en  = 1'b0;
      grant_valid = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_id  <= grant_id_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Directed bench for fifo_wr_rr_arbiter: per-requester producer queues, checks at negedge.
// Inputs change 1 time unit after posedge; outputs are sampled at the following negedge.
// Producers pop a beat only when they saw valid & ready, so backpressure is honoured.
module tb_fifo_wr_rr_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           fifo_full = 1'b0;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_wr_data;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] q [N][$];

  // Hand-computed per-cycle expectations for T1 and T3.
  int t1_wr [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
  int t1_gv [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
  int t1_ix [10] = '{0, 0, 1, 2, 3, 0, 4, 5, 0, 0};
  int t3_wr [9]  = '{0, 1, 0, 0, 0, 1, 1, 1, 0};
  int t3_gv [9]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int t3_ix [9]  = '{0, 0, 0, 0, 0, 1, 2, 3, 0};

  fifo_wr_rr_arbiter #(.N_REQ(N), .F_WIDTH(W), .MAX_BURST(4), .ID_W(IDW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (q[i].size() != 0);
      req_data[i*W +: W] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  // Called at negedge: pops the beats accepted this cycle, moves to the next cycle start.
  task automatic advance();
    logic [N-1:0] acc;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) void'(q[i].pop_front());
    end
    drive();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    fifo_full = 1'b0;
    drive();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    fifo_full = 1'b0;
    q[0].push_back(32'h55);
    drive();
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: gv=%b wr_en=%b rdy=%b, need 0 0 0000", grant_valid, fifo_wr_en, req_ready);
    end
    advance();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b0 || fifo_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_idle: gv=%b wr_en=%b, need 0 0", grant_valid, fifo_wr_en);
    end
    advance();
    @(negedge clk);
    n_checks++;
    if (fifo_wr_en !== 1'b1 || grant_id !== 2'd0 || fifo_wr_data !== 32'h55) begin
      n_fail++;
      $display("FAIL reset_first_write: wr_en=%b id=%0d data=%h, need 1 0 00000055", fifo_wr_en, grant_id, fifo_wr_data);
    end
    advance();
  endtask

  task automatic test_single_burst_split();
    apply_reset();
    for (int k = 0; k < 6; k++) q[0].push_back(32'hA0 + k);
    drive();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (fifo_wr_en !== t1_wr[c][0] || grant_valid !== t1_gv[c][0]) begin
        n_fail++;
        $display("FAIL t1_wr_gv cyc %0d: wr_en=%b gv=%b, need %0d %0d", c, fifo_wr_en, grant_valid, t1_wr[c], t1_gv[c]);
      end
      if (t1_wr[c] == 1) begin
        n_checks++;
        if (fifo_wr_data !== 32'hA0 + t1_ix[c] || req_ready !== 4'b0001) begin
          n_fail++;
          $display("FAIL t1_data cyc %0d: data=%h rdy=%b, need %h 0001", c, fifo_wr_data, req_ready, 32'hA0 + t1_ix[c]);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rdy;
    int g;
    apply_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 12; k++) q[i].push_back(32'(i * 256 + k));
    drive();
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b0 || fifo_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_first_idle: gv=%b wr_en=%b, need 0 0", grant_valid, fifo_wr_en);
    end
    advance();
    for (int b = 0; b < 5; b++) begin
      g = b % 4;
      exp_rdy = 4'b0001 << g;
      for (int beat = 0; beat < 4; beat++) begin
        @(negedge clk);
        n_checks++;
        if (fifo_wr_en !== 1'b1 || grant_valid !== 1'b1 || grant_id !== IDW'(g) || req_ready !== exp_rdy ||
            fifo_wr_data !== 32'(g * 256 + (b / 4) * 4 + beat)) begin
          n_fail++;
          $display("FAIL t2_beat b%0d/%0d: wr_en=%b id=%0d rdy=%b data=%h, need 1 %0d %b %h", b, beat, fifo_wr_en,
                   grant_id, req_ready, fifo_wr_data, g, exp_rdy, 32'(g * 256 + (b / 4) * 4 + beat));
        end
        advance();
      end
      @(negedge clk);
      n_checks++;
      if (fifo_wr_en !== 1'b0 || grant_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL t2_bubble after burst %0d: wr_en=%b gv=%b, need 0 0", b, fifo_wr_en, grant_valid);
      end
      advance();
    end
  endtask

  task automatic test_full_stall();
    logic [3:0] exp_rdy;
    apply_reset();
    for (int k = 0; k < 4; k++) q[2].push_back(32'hC0 + k);
    drive();
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 2 && c <= 4);
      exp_rdy = (t3_gv[c] == 1 && !fifo_full) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      n_checks++;
      if (fifo_wr_en !== t3_wr[c][0] || grant_valid !== t3_gv[c][0] || req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL t3_ctrl cyc %0d: wr_en=%b gv=%b rdy=%b, need %0d %0d %b", c, fifo_wr_en, grant_valid,
                 req_ready, t3_wr[c], t3_gv[c], exp_rdy);
      end
      if (t3_gv[c] == 1) begin
        n_checks++;
        if (grant_id !== 2'd2 || (t3_wr[c] == 1 && fifo_wr_data !== 32'hC0 + t3_ix[c])) begin
          n_fail++;
          $display("FAIL t3_grant cyc %0d: id=%0d data=%h, need 2 %h", c, grant_id, fifo_wr_data, 32'hC0 + t3_ix[c]);
        end
      end
      advance();
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_early_drop();
    apply_reset();
    q[1].push_back(32'hB0);
    q[1].push_back(32'hB1);
    drive();
    @(negedge clk);
    advance();
    q[0].push_back(32'hE0);
    q[3].push_back(32'hF0);
    drive();
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (fifo_wr_en !== 1'b1 || grant_id !== 2'd1 || fifo_wr_data !== 32'hB0 + c - 1) begin
        n_fail++;
        $display("FAIL t4_beat cyc %0d: wr_en=%b id=%0d data=%h, need 1 1 %h", c, fifo_wr_en, grant_id, fifo_wr_data,
                 32'hB0 + c - 1);
      end
      advance();
    end
    @(negedge clk);
    n_checks++;
    if (fifo_wr_en !== 1'b0 || grant_valid !== 1'b1 || req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL t4_drop: wr_en=%b gv=%b rdy=%b, need 0 1 0010", fifo_wr_en, grant_valid, req_ready);
    end
    advance();
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_idle: gv=%b, need 0", grant_valid);
    end
    advance();
    @(negedge clk);
    n_checks++;
    if (fifo_wr_en !== 1'b1 || grant_id !== 2'd3 || fifo_wr_data !== 32'hF0) begin
      n_fail++;
      $display("FAIL t4_next_grant: wr_en=%b id=%0d data=%h, need 1 3 000000f0", fifo_wr_en, grant_id, fifo_wr_data);
    end
    advance();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    q[2].push_back(32'hD0);
    drive();
    @(negedge clk);
    advance();
    @(negedge clk);
    advance();
    @(negedge clk);
    advance();
    for (int k = 0; k < 4; k++) q[1].push_back(32'h10 + k);
    drive();
    @(negedge clk);
    advance();
    @(negedge clk);
    n_checks++;
    if (fifo_wr_en !== 1'b1 || grant_id !== 2'd1 || fifo_wr_data !== 32'h10) begin
      n_fail++;
      $display("FAIL t5_pre: wr_en=%b id=%0d data=%h, need 1 1 00000010", fifo_wr_en, grant_id, fifo_wr_data);
    end
    advance();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_wr_en !== 1'b0 || grant_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL t5_in_reset: wr_en=%b gv=%b rdy=%b, need 0 0 0000", fifo_wr_en, grant_valid, req_ready);
    end
    advance();
    rst_n = 1'b1;
    q[0].push_back(32'h20);
    q[3].push_back(32'h30);
    drive();
    @(negedge clk);
    n_checks++;
    if (fifo_wr_en !== 1'b0 || grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_idle: wr_en=%b gv=%b, need 0 0", fifo_wr_en, grant_valid);
    end
    advance();
    @(negedge clk);
    n_checks++;
    if (fifo_wr_en !== 1'b1 || grant_id !== 2'd0 || fifo_wr_data !== 32'h20) begin
      n_fail++;
      $display("FAIL t5_rr_ptr: wr_en=%b id=%0d data=%h, need 1 0 00000020", fifo_wr_en, grant_id, fifo_wr_data);
    end
    advance();
    @(negedge clk);
    advance();
    @(negedge clk);
    advance();
    @(negedge clk);
    n_checks++;
    if (fifo_wr_en !== 1'b1 || grant_id !== 2'd1 || fifo_wr_data !== 32'h11) begin
      n_fail++;
      $display("FAIL t5_resume: wr_en=%b id=%0d data=%h, need 1 1 00000011", fifo_wr_en, grant_id, fifo_wr_data);
    end
    advance();
  endtask

  task automatic test_random_traffic();
    int exp_seq [N];
    int pushed [N];
    int cyc;
    logic any;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      exp_seq[i] = 0;
      pushed[i]  = 0;
    end
    cyc = 0;
    any = 1'b1;
    while (cyc < 1200 && (cyc < 500 || any)) begin
      if (cyc < 500) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 7) == 0) begin
            q[i].push_back(32'(i * 32'h0100_0000 + pushed[i]));
            pushed[i]++;
          end
        end
        fifo_full = ($urandom_range(0, 3) == 0);
      end else begin
        fifo_full = 1'b0;
      end
      drive();
      @(negedge clk);
      n_checks++;
      if ((req_ready & (req_ready - 4'd1)) !== 4'b0000 || fifo_wr_en !== |(req_valid & req_ready)) begin
        n_fail++;
        $display("FAIL t6_handshake cyc %0d: rdy=%b vld=%b wr_en=%b", cyc, req_ready, req_valid, fifo_wr_en);
      end
      if (fifo_wr_en === 1'b1) begin
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) begin
            n_checks++;
            if (fifo_wr_data !== 32'(i * 32'h0100_0000 + exp_seq[i])) begin
              n_fail++;
              $display("FAIL t6_order cyc %0d req %0d: data=%h, need %h", cyc, i, fifo_wr_data,
                       32'(i * 32'h0100_0000 + exp_seq[i]));
            end
            exp_seq[i]++;
          end
        end
      end
      advance();
      any = 1'b0;
      for (int i = 0; i < N; i++) if (q[i].size() != 0) any = 1'b1;
      cyc++;
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (exp_seq[i] != pushed[i]) begin
        n_fail++;
        $display("FAIL t6_drain req %0d: written=%0d, pushed=%0d", i, exp_seq[i], pushed[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst_split();
    test_back_to_back();
    test_full_stall();
    test_early_drop();
    test_reset_mid_burst();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
